fwd_scoreboard: RTL

- Parametrised successor to the fixed two-stage forwarding unit.
- Tracks every pending register write per architectural register, each with its own result latency (ALU 1, load 2, mul/div up to MAXLAT).
- Generates, per source operand at decode, either a bypass-stage select or a stall.
- Sits between decode/issue and the operand muxes; replaces hard-coded EX/MEM–MEM/WB compare logic, so variable-latency units and deeper writeback paths work without rewiring.

---
 rtl/fwd_scoreboard_pkg.sv | 27 ++
 rtl/fwd_scoreboard_if.sv | 42 ++++
 rtl/fwd_scoreboard_entry.sv | 102 ++++++++++
 rtl/fwd_scoreboard.sv | 92 +++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_pkg
// Brief    : Shared types, widths and forward-select encoding for the scoreboard.
// Revision : 1.0
// ============================================================================
package fwd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BYP  = 2'd2
  } entry_state_e;

  localparam int FWD_RF   = 0;
  localparam int FWD_BYP1 = 1;

  function automatic int calc_cw(input int maxlat);
    return $clog2(maxlat + 1);
  endfunction

  function automatic int calc_sw(input int wbd);
    return $clog2(wbd + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard_if
// Brief    : Decode-side issue/lookup bundle between decode and the scoreboard.
// Revision : 1.0
// ============================================================================
interface fwd_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MAXLAT = 8,
  parameter int WBD    = 2
);
  localparam int CW = calc_cw(MAXLAT);
  localparam int SW = calc_sw(WBD);

  logic                 hold;
  logic                 issue_valid;
  logic                 issue_wr;
  logic [AW-1:0]        issue_rd;
  logic [CW-1:0]        issue_lat;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC-1:0]      src_used;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic                 raw_stall;
  logic                 waw_stall;
  logic                 stall;
  logic                 pending_any;

  modport master (
    output hold, issue_valid, issue_wr, issue_rd, issue_lat, src_addr, src_used,
    input  fwd_sel, raw_stall, waw_stall, stall, pending_any
  );

  modport slave (
    input  hold, issue_valid, issue_wr, issue_rd, issue_lat, src_addr, src_used,
    output fwd_sel, raw_stall, waw_stall, stall, pending_any
  );

endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_entry
// Brief    : Per-register pending-write tracker: IDLE -> WAIT(cnt) -> BYP(age).
// Revision : 1.0
// ============================================================================
module scoreboard_entry
  import fwd_pkg::*;
#(
  parameter int MAXLAT = 8,
  parameter int WBD    = 2,
  parameter int CW     = calc_cw(MAXLAT),
  parameter int SW     = calc_sw(WBD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set,
  input  logic [CW-1:0] i_set_lat,
  input  logic          i_hold,
  output logic          o_is_wait,
  output logic          o_is_byp,
  output logic [SW-1:0] o_age
);

  localparam logic [CW-1:0] C_MAXLAT   = CW'(MAXLAT);
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [SW-1:0] C_LAST_AGE = SW'(WBD - 1);

  entry_state_e  r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_lat;
  logic [SW-1:0] r_age, w_age_nxt;

  // Latency 0 behaves as 1; anything beyond MAXLAT saturates.
  always_comb begin
    w_lat = i_set_lat;
    if (i_set_lat == '0) begin
      w_lat = C_ONE;
    end else if (i_set_lat > C_MAXLAT) begin
      w_lat = C_MAXLAT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_age   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_age   <= w_age_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_age_nxt   = r_age;
    if (!i_hold) begin
      if (i_set) begin
        if (w_lat <= C_ONE) begin
          w_state_nxt = ST_BYP;
          w_cnt_nxt   = '0;
          w_age_nxt   = '0;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = w_lat - C_ONE;
          w_age_nxt   = '0;
        end
      end else begin
        case (r_state)
          ST_WAIT: begin
            if (r_cnt <= C_ONE) begin
              w_state_nxt = ST_BYP;
              w_cnt_nxt   = '0;
              w_age_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt - C_ONE;
            end
          end
          ST_BYP: begin
            if (r_age >= C_LAST_AGE) begin
              w_state_nxt = ST_IDLE;
              w_age_nxt   = '0;
            end else begin
              w_age_nxt = r_age + SW'(1);
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_is_wait = (r_state == ST_WAIT);
  assign o_is_byp  = (r_state == ST_BYP);
  assign o_age     = r_age;

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Brief    : Variable-latency forwarding scoreboard producing bypass selects/stalls.
// Revision : 1.0
// ============================================================================
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int AW     = 5,
  parameter int NSRC   = 2,
  parameter int MAXLAT = 8,
  parameter int WBD    = 2
) (
  input  logic             clk,
  input  logic             reset,
  fwd_scoreboard_if.slave  bus
);

  localparam int CW   = calc_cw(MAXLAT);
  localparam int SW   = calc_sw(WBD);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0]    w_wait;
  logic [NREG-1:0]    w_byp;
  logic [NREG*SW-1:0] w_age;
  logic               w_accept;
  logic               w_raw;
  logic               w_waw;
  logic               w_stall;
  logic [NSRC*SW-1:0] w_fwd;
  logic [AW-1:0]      w_src;

  // Register 0 is hard-wired idle so lookups on it never forward or stall.
  assign w_wait[0]     = 1'b0;
  assign w_byp[0]      = 1'b0;
  assign w_age[SW-1:0] = '0;

  generate
    for (genvar k = 1; k < NREG; k++) begin : g_entry
      logic w_set;
      assign w_set = w_accept && (bus.issue_rd == AW'(k));

      scoreboard_entry #(
        .MAXLAT (MAXLAT),
        .WBD    (WBD),
        .CW     (CW),
        .SW     (SW)
      ) u_entry (
        .clk       (clk),
        .rst       (reset),
        .i_set     (w_set),
        .i_set_lat (bus.issue_lat),
        .i_hold    (bus.hold),
        .o_is_wait (w_wait[k]),
        .o_is_byp  (w_byp[k]),
        .o_age     (w_age[k*SW +: SW])
      );
    end
  endgenerate

  always_comb begin
    w_raw = 1'b0;
    w_fwd = {NSRC{SW'(FWD_RF)}};
    w_src = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_src = bus.src_addr[i*AW +: AW];
      if (bus.src_used[i]) begin
        if (w_wait[w_src]) begin
          w_raw = 1'b1;
        end
        if (w_byp[w_src]) begin
          w_fwd[i*SW +: SW] = w_age[w_src*SW +: SW] + SW'(FWD_BYP1);
        end
      end
    end
  end

  // Lookups see current state only, so a source equal to its own rd reads the older producer.
  assign w_waw    = bus.issue_wr && (bus.issue_rd != '0) && w_wait[bus.issue_rd];
  assign w_stall  = bus.issue_valid && (w_raw || w_waw);
  assign w_accept = bus.issue_valid && bus.issue_wr && (bus.issue_rd != '0)
                    && !w_stall && !bus.hold;

  assign bus.fwd_sel     = w_fwd;
  assign bus.raw_stall   = w_raw;
  assign bus.waw_stall   = w_waw;
  assign bus.stall       = w_stall;
  assign bus.pending_any = |(w_wait | w_byp);

endmodule
`default_nettype wire
